// File: rtl/mem_xfer_master.sv
// ---------------------------------------------------------------------------
// mem_xfer_master
//
// Initiator-side transfer engine for the 16-bit data memory port. It has two
// modes:
//   dump (mode=0) : reads `length` words starting at `base_addr` and streams
//                   them out on tx_data/tx_valid/tx_ready.
//   load (mode=1) : accepts `length` words on rx_data/rx_valid/rx_ready and
//                   writes them to consecutive memory addresses.
// Addresses wrap modulo MEM_DEPTH. Every output is driven from a register.
//
// Optional feature (macro MEM_XFER_CRC_EN): a CRC-16-CCITT (poly 0x1021,
// init 0xFFFF, MSB first) is kept over the data words. A dump appends the CRC
// as one extra tx word. A load takes one extra rx word, compares it with the
// computed CRC, and raises crc_err on mismatch. Without the macro crc_err is 0.
//
// Ports:
//   clk, reset         clock (posedge), asynchronous active-low reset
//   start              one-cycle request, honoured only when idle
//   mode               0 = dump, 1 = load (latched at start)
//   base_addr, length  first word address and word count (latched at start)
//   busy, done         transfer in progress / one-cycle completion pulse
//   crc_err            load trailer mismatch flag
//   tx_data/tx_valid/tx_ready   dump stream (this block is the source)
//   rx_data/rx_valid/rx_ready   load stream (this block is the sink)
//   mem_addr/mem_wdata/mem_we   memory request; memory writes on negedge
//   mem_rdata          combinational read data for mem_addr
// ---------------------------------------------------------------------------
module mem_xfer_master #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 512,
    parameter int LEN_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              crc_err,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_HOLD, S_LD, S_WR, S_CRC_TX, S_CRC_RX, S_DONE
    } state_e;

`ifdef MEM_XFER_CRC_EN
    localparam state_e AFTER_TX = S_CRC_TX;
    localparam state_e AFTER_RX = S_CRC_RX;
`else
    localparam state_e AFTER_TX = S_DONE;
    localparam state_e AFTER_RX = S_DONE;
`endif

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              tx_valid_q, tx_valid_d;
    logic              rx_ready_q, rx_ready_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic tx_hs, rx_hs, last_word;

    assign tx_hs     = tx_valid_q & tx_ready;
    assign rx_hs     = rx_valid & rx_ready_q;
    // Only evaluated once a transfer with length >= 1 is running.
    assign last_word = (cnt_q == len_q - LEN_W'(1));

    function automatic logic [ADDR_W-1:0] addr_wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

`ifdef MEM_XFER_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic        crc_err_q, crc_err_d;

    // Whole word folded into the CRC in a single cycle, MSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] c,
                                               input logic [DATA_W-1:0] d);
        logic [15:0] r;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

    // State and output registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge value of the others; blocking here would chain updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            tx_data_q  <= '0;
            wdata_q    <= '0;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MEM_XFER_CRC_EN
            crc_q      <= '0;
            crc_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            wdata_q    <= wdata_d;
            tx_valid_q <= tx_valid_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef MEM_XFER_CRC_EN
            crc_q      <= crc_d;
            crc_err_q  <= crc_err_d;
`endif
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (length == '0) ? S_DONE : (mode ? S_LD : S_RD);
            S_RD:     state_d = S_HOLD;
            S_HOLD:   if (tx_hs) state_d = last_word ? AFTER_TX : S_RD;
            S_LD:     if (rx_hs) state_d = S_WR;
            S_WR:     state_d = last_word ? AFTER_RX : S_LD;
            S_CRC_TX: if (tx_hs) state_d = S_DONE;
            S_CRC_RX: if (rx_hs) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values. Flags are derived from the state being
    // entered so that, once registered, they line up with that state.
    always_comb begin
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        tx_valid_d = (state_d == S_HOLD) || (state_d == S_CRC_TX);
        rx_ready_d = (state_d == S_LD)   || (state_d == S_CRC_RX);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
`ifdef MEM_XFER_CRC_EN
        crc_d      = crc_q;
        crc_err_d  = crc_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d  = length;
                    addr_d = base_addr % ADDR_W'(MEM_DEPTH);
                    cnt_d  = '0;
`ifdef MEM_XFER_CRC_EN
                    crc_d     = 16'hFFFF;
                    crc_err_d = 1'b0;
`endif
                end
            end
            S_RD: begin
                tx_data_d = mem_rdata;
`ifdef MEM_XFER_CRC_EN
                crc_d = crc16_word(crc_q, mem_rdata);
`endif
            end
            S_HOLD: begin
                if (tx_hs) begin
                    if (last_word) begin
`ifdef MEM_XFER_CRC_EN
                        tx_data_d = crc_q;
`endif
                    end else begin
                        cnt_d  = cnt_q + LEN_W'(1);
                        addr_d = addr_wrap_inc(addr_q);
                    end
                end
            end
            S_LD: begin
                if (rx_hs) begin
                    wdata_d = rx_data;
                    we_d    = 1'b1;
`ifdef MEM_XFER_CRC_EN
                    crc_d = crc16_word(crc_q, rx_data);
`endif
                end
            end
            S_WR: begin
                if (!last_word) begin
                    cnt_d  = cnt_q + LEN_W'(1);
                    addr_d = addr_wrap_inc(addr_q);
                end
            end
            S_CRC_RX: begin
`ifdef MEM_XFER_CRC_EN
                if (rx_hs) crc_err_d = (rx_data != crc_q);
`endif
            end
            default: ;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign rx_ready  = rx_ready_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;

endmodule

// File: doc/mem_xfer_master.md
Name: mem_xfer_master

Overview:
- Initiator-side engine for the 16-bit data memory port: drives address, write-enable and write-data; samples combinational read data.
- Two modes:
  - Dump: reads a block of words from memory and streams it out on a valid/ready interface, for example toward a UART TX.
  - Load: accepts a stream of words, for example from a UART RX, and writes them to consecutive memory addresses.
- Sits between the serial link logic and the data memory, alongside the CPU's access path.

Parameters:
- DATA_W, 16, word width of memory and streams.
- ADDR_W, 16, memory address width.
- MEM_DEPTH, 512, number of memory words; addresses wrap modulo MEM_DEPTH.
- LEN_W, 10, width of the transfer length field.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode  input  1  0 = dump (mem->tx), 1 = load (rx->mem); latched at start.
- base_addr  input  ADDR_W  first word address; latched at start.
- length  input  LEN_W  number of data words; latched at start.
- busy  output  1  high from the cycle after accepted start until the DONE cycle inclusive.
- done  output  1  one-cycle completion pulse.
- crc_err  output  1  load CRC mismatch flag; 0 without the optional feature.
- tx_data  output  DATA_W  dump stream data.
- tx_valid  output  1  dump stream valid.
- tx_ready  input  1  dump stream ready.
- rx_data  input  DATA_W  load stream data.
- rx_valid  input  1  load stream valid.
- rx_ready  output  1  load stream ready.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_we  output  1  memory write enable.
- mem_rdata  input  DATA_W  memory read data, combinational from mem_addr.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and CRC cleared. Reset mid-transfer aborts immediately with no done pulse. A write already issued is not retracted.
- All outputs are registered. The memory samples writes on negedge clk, so a one-cycle mem_we pulse commits mid-cycle.
- States: IDLE, RD, HOLD, LD, WR, CRC_TX, CRC_RX, DONE.
- IDLE:
  - On start, latch mode/base/length and set mem_addr = base_addr mod MEM_DEPTH; cnt = 0.
  - length = 0 -> DONE, with no memory or stream activity.
  - Otherwise go to RD (mode 0) or LD (mode 1).
- RD: capture mem_rdata into tx_data, set tx_valid = 1, -> HOLD.
- HOLD:
  - tx_data/tx_valid held stable until tx_ready.
  - On tx_valid & tx_ready: tx_valid = 0.
  - If cnt == length-1 -> CRC_TX (feature on) or DONE.
  - Else cnt++, mem_addr = (mem_addr+1) mod MEM_DEPTH, -> RD.
- Dump throughput is at most one word per 2 cycles.
- LD:
  - rx_ready = 1.
  - On rx_valid & rx_ready: mem_wdata = rx_data, mem_we = 1, rx_ready = 0, -> WR.
- WR:
  - mem_we = 0.
  - If cnt == length-1 -> CRC_RX (feature on) or DONE.
  - Else cnt++, mem_addr++ (wrapped), -> LD.
- DONE: done = 1 for one cycle, busy = 1 this cycle, -> IDLE. busy = 0 and done = 0 in IDLE.
- start while not IDLE is ignored.
- mem_we is never high in dump mode. tx_valid is never high in load mode.

Optional Feature:
- Macro: MEM_XFER_CRC_EN.
- With the macro defined:
  - CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Updated over each 16-bit data word, MSB first; all 16 bits processed in one cycle.
  - Dump: CRC_TX presents the CRC as one extra tx word with the same handshake, then DONE.
  - Load: CRC_RX accepts one extra rx word, compares it to the computed CRC, and writes nothing to memory.
  - crc_err is set on mismatch, held until the next accepted start (cleared then) or reset. Then DONE.
  - CRC is reinitialised at each accepted start.
- Without the macro: no CRC states, no extra stream word, crc_err tied 0.

Test Plan:
- Memory at reset content (mem[i] = i); dump base=5 length=3, tx_ready=1 -> tx words 0x0005, 0x0006, 0x0007; done pulses once; mem_we never 1.
- Dump base=510 length=4 -> tx words 0x01FE, 0x01FF, 0x0000, 0x0001 (address wrap).
- Dump length=2 with tx_ready low for 5 cycles on each word -> tx_data stable while waiting; no word lost or duplicated.
- Load base=0x20 length=3, rx 0xA5A5, 0x1234, 0xBEEF with gaps in rx_valid, then dump same range -> reads back identical words; start pulsed mid-load is ignored.
- length=0 -> done one cycle after start; no mem_we, tx_valid or rx_ready activity.
- Assert reset during a dump at word 2 -> all outputs 0 immediately, no done.
- MEM_XFER_CRC_EN defined:
  - Dump's extra word equals the model CRC.
  - Load with a correct trailer gives crc_err = 0; a corrupted trailer gives crc_err = 1.
